udp_writer: RTL and testbench

- Transmit-side counterpart of udp_reader, in the rgmii_clk domain.
- Snapshots a CAPACITY-byte status/command word and sends it as one UDP payload through udp_packet's TX interface (trig, tx_read_en, tx_data, tx_data_len).
- Bytes are sent MSB-first (network order), so a PC-side echo of udp_reader's payload round-trips byte-for-byte.
- Sits beside u_udp_reader; the PC uses it to read back board state.

---
 rtl/udp_writer.sv | 102 ++++++++++
 tb/tb_udp_writer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/udp_writer.sv
// Snapshots a CAPACITY-byte word and streams it MSB-first through udp_packet's TX port.
// Flow: request -> one-cycle trig -> wait for the first read_en -> one byte per read_en.
module udp_writer #(
  parameter int CAPACITY = 4,
  parameter int TIMEOUT  = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic [CAPACITY*8-1:0] i_data,
  output logic                  o_trig,
  input  logic                  read_en,
  output logic [7:0]            o_data,
  output logic [15:0]           data_len,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  cap_err
);

  localparam int CW = $clog2(CAPACITY + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(CAPACITY);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, SEND} state_t;

  state_t                r_state;
  logic [CAPACITY*8-1:0] r_snap;
  logic [CW-1:0]         r_cnt;
  logic [TW-1:0]         r_tcnt;
  logic [7:0]            w_byte;

  assign data_len = 16'(CAPACITY);

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_byte = '0;
    for (int k = 0; k < CAPACITY; k++) begin
      if (r_cnt == CW'(k)) w_byte = r_snap[(CAPACITY-1-k)*8 +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_cnt       <= '0;
      r_tcnt      <= '0;
      o_trig      <= 1'b0;
      o_data      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      cap_err     <= 1'b0;
    end else begin
      o_trig      <= 1'b0;
      timeout_err <= 1'b0;
      cap_err     <= read_en && (r_cnt == CNT_FULL);

      case (r_state)
        IDLE: begin
          if (send) begin
            r_snap  <= i_data;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= TRIG;
          end
        end
        TRIG: begin
          o_trig  <= 1'b1;
          r_tcnt  <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // read_en takes priority over an expiring timeout on the same cycle.
          if (read_en) begin
            o_data  <= w_byte;
            r_cnt   <= r_cnt + CW'(1);
            r_state <= SEND;
          end else if (r_tcnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        SEND: begin
          if (r_cnt == CNT_FULL) begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end else if (read_en) begin
            o_data <= w_byte;
            r_cnt  <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_writer.sv
// Directed bench for udp_writer (CAPACITY=4, TIMEOUT=16); inputs change and outputs are sampled 1ns after each rising edge.
module tb_udp_writer;

  localparam int CAP = 4;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           send;
  logic [CAP*8-1:0] i_data;
  logic           o_trig;
  logic           read_en;
  logic [7:0]     o_data;
  logic [15:0]    data_len;
  logic           busy;
  logic           timeout_err;
  logic           cap_err;

  int checks = 0;
  int errors = 0;

  udp_writer #(.CAPACITY(CAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .send(send), .i_data(i_data), .o_trig(o_trig),
    .read_en(read_en), .o_data(o_data), .data_len(data_len), .busy(busy),
    .timeout_err(timeout_err), .cap_err(cap_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; send = 1'b0; read_en = 1'b0; i_data = '0;
    step(); step();
    checks++;
    if ({o_trig, busy, timeout_err, cap_err} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {o_trig, busy, timeout_err, cap_err});
    end
    checks++;
    if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
    checks++;
    if (data_len !== 16'd4) begin errors++; $display("FAIL reset_len: got %0d expected 4", data_len); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    i_data = 32'hDEADBEEF; send = 1'b1;
    step(); send = 1'b0;
    checks++;
    if (o_trig !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_accept: trig=%b busy=%b expected trig=0 busy=1", o_trig, busy);
    end
    step();
    checks++;
    if (o_trig !== 1'b1) begin errors++; $display("FAIL basic_trig: got %b expected 1", o_trig); end
    read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (o_data !== exp_b[i] || o_trig !== 1'b0 || data_len !== 16'd4) begin
        errors++; $display("FAIL basic_byte%0d: got %h trig=%b len=%0d expected %h trig=0 len=4", i, o_data, o_trig, data_len, exp_b[i]);
      end
    end
    read_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_hold: got %b expected 1", busy); end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
  endtask

  task automatic test_gaps_and_overread();
    logic [7:0] exp_b [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    i_data = 32'hDEADBEEF; send = 1'b1;
    step(); send = 1'b0;
    step();
    checks++;
    if (o_trig !== 1'b1) begin errors++; $display("FAIL gap_trig: got %b expected 1", o_trig); end
    for (int i = 0; i < 4; i++) begin
      read_en = 1'b1;
      step();
      if (i == 0) i_data = '0;
      checks++;
      if (o_data !== exp_b[i]) begin errors++; $display("FAIL gap_byte%0d: got %h expected %h", i, o_data, exp_b[i]); end
      read_en = 1'b0;
      step();
      checks++;
      if (o_data !== exp_b[i]) begin errors++; $display("FAIL gap_hold%0d: got %h expected %h", i, o_data, exp_b[i]); end
    end
    checks++;
    if (busy !== 1'b0 || cap_err !== 1'b0) begin
      errors++; $display("FAIL gap_done: busy=%b cap_err=%b expected 0 0", busy, cap_err);
    end
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    checks++;
    if (cap_err !== 1'b1 || o_data !== 8'hEF) begin
      errors++; $display("FAIL overread_pulse: cap_err=%b data=%h expected 1 EF", cap_err, o_data);
    end
    step();
    checks++;
    if (cap_err !== 1'b0 || o_data !== 8'hEF) begin
      errors++; $display("FAIL overread_clear: cap_err=%b data=%h expected 0 EF", cap_err, o_data);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int n;
    i_data = 32'h01020304; send = 1'b1;
    step(); send = 1'b0;
    step();
    checks++;
    if (o_trig !== 1'b1) begin errors++; $display("FAIL tmo_trig: got %b expected 1", o_trig); end
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != TO) begin errors++; $display("FAIL tmo_delay: got %0d cycles expected %0d", n, TO); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", busy); end
    step();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b expected 0", timeout_err); end
    send = 1'b1;
    step(); send = 1'b0;
    step();
    checks++;
    if (o_trig !== 1'b1) begin errors++; $display("FAIL tmo_retrig: got %b expected 1", o_trig); end
    read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (o_data !== exp_b[i]) begin errors++; $display("FAIL tmo_byte%0d: got %h expected %h", i, o_data, exp_b[i]); end
    end
    read_en = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL tmo_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_send_held();
    int trig_cnt = 0;
    int tmo_cnt  = 0;
    int first_t  = -1;
    int second_t = -1;
    send = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      if (s == 21) send = 1'b0;
      step();
      if (o_trig === 1'b1) begin
        trig_cnt++;
        if (trig_cnt == 1) first_t = s;
        if (trig_cnt == 2) second_t = s;
      end
      if (timeout_err === 1'b1) tmo_cnt++;
    end
    checks++;
    if (trig_cnt != 2) begin errors++; $display("FAIL held_trig_count: got %0d expected 2", trig_cnt); end
    checks++;
    if (first_t != 2 || second_t != 20) begin
      errors++; $display("FAIL held_trig_times: got %0d,%0d expected 2,20", first_t, second_t);
    end
    checks++;
    if (tmo_cnt != 2 || busy !== 1'b0) begin
      errors++; $display("FAIL held_timeouts: got %0d busy=%b expected 2 busy=0", tmo_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] exp_b [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    i_data = 32'hDEADBEEF; send = 1'b1;
    step(); send = 1'b0;
    step();
    read_en = 1'b1;
    step(); step();
    checks++;
    if (o_data !== 8'hAD) begin errors++; $display("FAIL rmid_pre: got %h expected AD", o_data); end
    rst = 1'b1;
    step();
    checks++;
    if ({o_trig, busy, timeout_err, cap_err} !== 4'b0 || o_data !== 8'h00 || data_len !== 16'd4) begin
      errors++; $display("FAIL rmid_reset: flags=%b data=%h len=%0d expected 0000 00 4",
                         {o_trig, busy, timeout_err, cap_err}, o_data, data_len);
    end
    rst = 1'b0; read_en = 1'b0;
    step();
    i_data = 32'hCAFEF00D; send = 1'b1;
    step(); send = 1'b0;
    step();
    checks++;
    if (o_trig !== 1'b1) begin errors++; $display("FAIL rmid_trig: got %b expected 1", o_trig); end
    read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (o_data !== exp_b[i] || timeout_err !== 1'b0 || cap_err !== 1'b0) begin
        errors++; $display("FAIL rmid_byte%0d: got %h tmo=%b cap=%b expected %h 0 0", i, o_data, timeout_err, cap_err, exp_b[i]);
      end
    end
    read_en = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b0 || cap_err !== 1'b0) begin
      errors++; $display("FAIL rmid_end: busy=%b tmo=%b cap=%b expected 0 0 0", busy, timeout_err, cap_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps_and_overread();
    test_timeout();
    test_send_held();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
